line_refill_engine: RTL
=======================

Name: line_refill_engine

Overview:
- Sits between the direct-mapped LRU cache controller and the DDR2 memory controller.
- Converts one cache-miss request into a sequence of single-beat (64-bit) memory transactions on the memory controller's start/loadstore handshake:
  - optional write-back of the dirty victim line, then
  - fill of the new line.
- Returns the assembled fill line to the cache in one response cycle. Provides a per-transaction timeout so a hung DDR transaction is reported, not deadlocked.

Parameters:
- BEATS, 4: 64-bit beats per cache line (power of two, 1..16).
- ADDR_W, 28: memory byte-address width.
- GAP_CYCLES, 2: idle cycles between a mem_transaction_complete and the next mem_start (lets the memory controller return to idle).
- TIMEOUT_CYCLES, 4096: maximum cycles spent waiting for mem_transaction_complete on any beat.

Ports:
- clk_cpu  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  miss request present.
- req_ready  out  1  engine idle; the request is accepted when req_valid && req_ready.
- req_dirty  in  1  victim line must be written back first.
- req_evict_addr  in  ADDR_W  victim line base address.
- req_fill_addr  in  ADDR_W  fill line base address.
- req_wb_data  in  BEATS*64  victim line; beat 0 in bits [63:0].
- resp_valid  out  1  one-cycle pulse: fill finished or aborted.
- resp_error  out  1  qualifies resp_valid; 1 means timeout abort.
- resp_data  out  BEATS*64  filled line; beat 0 in bits [63:0].
- busy  out  1  high in every state except IDLE.
- mem_start  out  1  one-cycle transaction strobe to the memory controller.
- mem_loadstore  out  1  1 = write, 0 = read; held stable for the whole beat.
- mem_addr  out  ADDR_W  beat address; held stable for the whole beat.
- mem_d_to_ram  out  64  write beat data; held stable for the whole beat.
- mem_d_from_ram  in  64  read data; valid in the cycle mem_transaction_complete is high.
- mem_transaction_complete  in  1  one-cycle completion pulse.
- mem_ready  in  1  DDR calibrated/ready.

Behaviour:
- Reset values:
  - State IDLE.
  - Low: mem_start, mem_loadstore, mem_addr, mem_d_to_ram, resp_valid, resp_error, resp_data, busy, and all counters.
  - req_ready = 1.
- Accept (IDLE, req_valid=1):
  - Capture all request fields. Force the low log2(BEATS*8) bits of both addresses to zero.
  - Clear the beat counter and resp_data.
  - Next state is WB_ISSUE if req_dirty, else FILL_ISSUE.
  - req_ready is 0 from the cycle after accept until the cycle after resp_valid.
- WB_ISSUE:
  - Drive mem_loadstore=1, mem_addr=evict_base+8*beat, mem_d_to_ram=wb beat.
  - If mem_ready, pulse mem_start for exactly one cycle and go to WB_WAIT. Otherwise hold with mem_start=0; no timeout counting here.
- WB_WAIT:
  - mem_start=0; the timeout counter increments every cycle.
  - On complete: clear the timer and go to WB_GAP.
- WB_GAP: count GAP_CYCLES, then either:
  - if beat==BEATS-1: clear beat, go to FILL_ISSUE;
  - else: beat+1, go to WB_ISSUE.
- FILL_ISSUE: same as WB_ISSUE with mem_loadstore=0 and mem_addr=fill_base+8*beat. mem_d_to_ram holds its last value (don't-care).
- FILL_WAIT:
  - On complete, write mem_d_from_ram into resp_data[64*beat +: 64].
  - Then go to FILL_GAP, which advances the beat the same way as WB_GAP.
  - After the last beat, go to RESP (no gap is required before RESP).
- RESP: resp_valid=1 and resp_error=0 for one cycle, then IDLE.
- Timeout:
  - Applies in WB_WAIT or FILL_WAIT. When the counter reaches TIMEOUT_CYCLES-1 without complete, go to RESP with resp_error=1.
  - resp_data holds the beats filled so far; unfilled beats are 0.
- Timing of resp_data and addresses:
  - resp_data is stable from resp_valid until the next accept.
  - Addresses increment by 8 and wrap within ADDR_W.
- Stray pulses: mem_transaction_complete while in IDLE/ISSUE/GAP/RESP is ignored.
- Reset mid-operation: immediate return to reset values. A memory transaction still in flight may complete later; that complete is ignored.
- Latency (clean fill, complete arriving L cycles after mem_start, mem_ready=1):
  - BEATS*(1+L+GAP_CYCLES) cycles from accept to resp_valid, within one cycle.
  - The last gap is skipped.
- Dirty request: the write-back phase adds BEATS*(1+L+GAP_CYCLES) cycles.

Test Plan:
- Clean fill, BEATS=4, fill_addr=0x0000123, memory model returns 0xA0..A3 per beat with L=5 → four reads at 0x120/0x128/0x130/0x138; mem_loadstore=0; resp_data={A3,A2,A1,A0}; resp_error=0; one resp_valid pulse.
- Dirty miss, evict_addr=0x0000200, wb beats 0x11..0x14, fill 0x400 → four writes at 0x200..0x218 with the matching data, then four reads at 0x400..0x418; no mem_start within GAP_CYCLES of any complete.
- mem_ready=0 for 50 cycles after accept → no mem_start and no timeout; first mem_start one cycle after mem_ready rises.
- Memory model never completes beat 2 → resp_valid with resp_error=1 exactly TIMEOUT_CYCLES after that beat's mem_start; beats 0-1 filled, beats 2-3 zero.
- rst asserted in WB_WAIT of beat 1, then complete arrives → all outputs at reset values next cycle; the stray complete is ignored; a new request runs normally.
- Back-to-back requests with req_valid held high → second accept in the cycle after resp_valid; its data does not corrupt the first response.

Source files
------------

// File: rtl/line_refill_engine.sv
// rtl/line_refill_engine.sv - cache line refill engine: optional victim write-back, then beat-wise line fill
module line_refill_engine #(
    parameter int BEATS          = 4,
    parameter int ADDR_W         = 28,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_cpu,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_dirty,
    input  logic [ADDR_W-1:0]     req_evict_addr,
    input  logic [ADDR_W-1:0]     req_fill_addr,
    input  logic [BEATS*64-1:0]   req_wb_data,
    output logic                  resp_valid,
    output logic                  resp_error,
    output logic [BEATS*64-1:0]   resp_data,
    output logic                  busy,
    output logic                  mem_start,
    output logic                  mem_loadstore,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [63:0]           mem_d_to_ram,
    input  logic [63:0]           mem_d_from_ram,
    input  logic                  mem_transaction_complete,
    input  logic                  mem_ready
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW = $clog2(BEATS * 8);
    localparam int CW = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 1);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0]     GAP_LAST  = CW'(GAP_CYCLES - 1);
    // Counter value one below the limit: the cycle after this one is the TIMEOUT_CYCLES-th since mem_start.
    localparam logic [CW-1:0]     TO_LAST   = CW'(TIMEOUT_CYCLES - 2);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << LW) - ADDR_W'(1));

    typedef enum logic [2:0] {
        S_IDLE, S_WB_ISSUE, S_WB_WAIT, S_WB_GAP,
        S_FILL_ISSUE, S_FILL_WAIT, S_FILL_GAP, S_RESP
    } state_t;

    state_t                state, state_n;
    logic [ADDR_W-1:0]     evict_base, fill_base;
    logic [BEATS*64-1:0]   wb_line;
    logic [BW-1:0]         beat, beat_inc;
    logic [CW-1:0]         cnt;
    logic                  err_flag;
    logic                  in_wb, in_fill, last_beat, gap_done, timeout_hit;
    logic [ADDR_W-1:0]     beat_off;

    assign beat_inc    = beat + BW'(1);
    assign last_beat   = (beat == LAST_BEAT);
    assign gap_done    = (cnt == GAP_LAST);
    assign timeout_hit = (cnt == TO_LAST);
    assign in_wb       = (state == S_WB_ISSUE) || (state == S_WB_WAIT) || (state == S_WB_GAP);
    assign in_fill     = (state == S_FILL_ISSUE) || (state == S_FILL_WAIT) || (state == S_FILL_GAP);
    assign beat_off    = {{(ADDR_W - BW - 3){1'b0}}, beat, 3'b000};

    // Address and direction derive from state and beat, so they stay put from issue through the gap.
    assign req_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign resp_valid    = (state == S_RESP);
    assign resp_error    = (state == S_RESP) && err_flag;
    assign mem_loadstore = in_wb;
    assign mem_addr      = in_wb ? (evict_base + beat_off) : in_fill ? (fill_base + beat_off) : '0;

    always_comb begin
        state_n   = state;
        mem_start = 1'b0;
        case (state)
            S_IDLE:       if (req_valid) state_n = req_dirty ? S_WB_ISSUE : S_FILL_ISSUE;
            S_WB_ISSUE:   if (mem_ready) begin
                              mem_start = 1'b1;
                              state_n   = S_WB_WAIT;
                          end
            S_WB_WAIT:    if (mem_transaction_complete) state_n = S_WB_GAP;
                          else if (timeout_hit)         state_n = S_RESP;
            S_WB_GAP:     if (gap_done) state_n = last_beat ? S_FILL_ISSUE : S_WB_ISSUE;
            S_FILL_ISSUE: if (mem_ready) begin
                              mem_start = 1'b1;
                              state_n   = S_FILL_WAIT;
                          end
            S_FILL_WAIT:  if (mem_transaction_complete) state_n = last_beat ? S_RESP : S_FILL_GAP;
                          else if (timeout_hit)         state_n = S_RESP;
            S_FILL_GAP:   if (gap_done) state_n = S_FILL_ISSUE;
            S_RESP:       state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state        <= S_IDLE;
            evict_base   <= '0;
            fill_base    <= '0;
            wb_line      <= '0;
            beat         <= '0;
            cnt          <= '0;
            err_flag     <= 1'b0;
            resp_data    <= '0;
            mem_d_to_ram <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: if (req_valid) begin
                    evict_base <= req_evict_addr & BASE_MASK;
                    fill_base  <= req_fill_addr & BASE_MASK;
                    wb_line    <= req_wb_data;
                    beat       <= '0;
                    cnt        <= '0;
                    err_flag   <= 1'b0;
                    resp_data  <= '0;
                    if (req_dirty) mem_d_to_ram <= req_wb_data[63:0];
                end
                S_WB_ISSUE, S_FILL_ISSUE: cnt <= '0;
                S_WB_WAIT, S_FILL_WAIT: begin
                    if (mem_transaction_complete) begin
                        cnt <= '0;
                        if (state == S_FILL_WAIT) resp_data[{beat, 6'd0} +: 64] <= mem_d_from_ram;
                    end else if (timeout_hit) begin
                        err_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WB_GAP, S_FILL_GAP: begin
                    if (gap_done) begin
                        cnt  <= '0;
                        beat <= last_beat ? '0 : beat_inc;
                        // Next write beat is staged here so it is valid in the first issue cycle.
                        if (state == S_WB_GAP && !last_beat) mem_d_to_ram <= wb_line[{beat_inc, 6'd0} +: 64];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
